regfile_check_sequencer: RTL and testbench

- Synthesizable self-check engine for CPU bring-up.
- Snoops the CPU register-file writeback port and keeps a shadow copy of the architectural registers.
- Steps through a programmed table of (flag value, register, expected value) checks; each stage is released when the flag register reaches that stage's value.
- Reports pass, fail or timeout with diagnostics. Generalises the flag-wait/check-register bench flow to N checks, with a per-stage timeout, so it can run on FPGA without a simulator.

---
 rtl/regfile_check_sequencer.sv | 176 +++++++++++++++++
 tb/tb_regfile_check_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_check_sequencer.sv
// Self-check engine: shadows the register-file writeback port and walks a table of
// flag-released register checks, reporting pass, mismatch or per-stage timeout.
module regfile_check_sequencer #(
    parameter int NUM_CHECKS     = 8,
    parameter int FLAG_REG       = 20,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int XLEN           = 32,
    localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [XLEN-1:0]  cfg_flag,
    input  logic [4:0]       cfg_reg,
    input  logic [XLEN-1:0]  cfg_value,
    input  logic [IDX_W:0]   cfg_count,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IDX_W-1:0] fail_idx,
    output logic [XLEN-1:0]  fail_got
);
    localparam int CNT_W  = IDX_W + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [CNT_W-1:0]  COUNT_MAX = CNT_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0]  COUNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [4:0]        FLAG_IDX  = 5'(FLAG_REG);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_PASS, S_FAIL} state_t;
    state_t state_reg, state_next;

    logic [IDX_W-1:0]  idx_reg;
    logic [TCNT_W-1:0] tcnt_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              timeout_reg;
    logic [IDX_W-1:0]  fail_idx_reg;
    logic [XLEN-1:0]   fail_got_reg;

    // Check table: deliberately not reset so a programmed table survives a reset.
    logic [XLEN-1:0] flag_mem  [NUM_CHECKS];
    logic [4:0]      reg_mem   [NUM_CHECKS];
    logic [XLEN-1:0] value_mem [NUM_CHECKS];

    logic [XLEN-1:0] shadow_reg [32];

    logic             cfg_open;
    logic             start_ok;
    logic [CNT_W-1:0] count_sel;
    logic [XLEN-1:0]  flag_now;
    logic [XLEN-1:0]  chk_now;
    logic             flag_hit;
    logic             chk_hit;
    logic             last_entry;
    logic             tcnt_last;

    assign cfg_open   = (state_reg == S_IDLE) || (state_reg == S_PASS) || (state_reg == S_FAIL);
    assign start_ok   = cfg_open && start;
    assign count_sel  = (cfg_count > COUNT_MAX) ? COUNT_MAX : cfg_count;
    assign flag_now   = shadow_reg[FLAG_IDX];
    assign chk_now    = shadow_reg[reg_mem[idx_reg]];
    assign flag_hit   = (flag_now == flag_mem[idx_reg]);
    assign chk_hit    = (chk_now == value_mem[idx_reg]);
    assign last_entry = ({1'b0, idx_reg} == (count_reg - COUNT_ONE));
    assign tcnt_last  = (tcnt_reg == TCNT_LAST);

    always_ff @(posedge clk) begin
        if (cfg_we && cfg_open && ({1'b0, cfg_idx} < COUNT_MAX)) begin
            flag_mem[cfg_idx]  <= cfg_flag;
            reg_mem[cfg_idx]   <= cfg_reg;
            value_mem[cfg_idx] <= cfg_value;
        end
    end

    // x0 is cleared on reset and never written, so it always reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            shadow_reg[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) begin
                    state_next = (count_sel == '0) ? S_PASS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flag_hit) begin
                    state_next = S_CHECK;
                end else if (tcnt_last) begin
                    state_next = S_FAIL;
                end
            end
            S_CHECK: begin
                if (!chk_hit) begin
                    state_next = S_FAIL;
                end else if (last_entry) begin
                    state_next = S_PASS;
                end else begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg      <= '0;
            tcnt_reg     <= '0;
            count_reg    <= '0;
            timeout_reg  <= 1'b0;
            fail_idx_reg <= '0;
            fail_got_reg <= '0;
        end else if (start_ok) begin
            idx_reg      <= '0;
            tcnt_reg     <= '0;
            count_reg    <= count_sel;
            timeout_reg  <= 1'b0;
            fail_idx_reg <= '0;
            fail_got_reg <= '0;
        end else if (state_reg == S_WAIT && !flag_hit) begin
            if (tcnt_last) begin
                timeout_reg  <= 1'b1;
                fail_idx_reg <= idx_reg;
                fail_got_reg <= flag_now;
            end else begin
                tcnt_reg <= tcnt_reg + TCNT_ONE;
            end
        end else if (state_reg == S_CHECK) begin
            if (!chk_hit) begin
                timeout_reg  <= 1'b0;
                fail_idx_reg <= idx_reg;
                fail_got_reg <= chk_now;
            end else if (!last_entry) begin
                idx_reg  <= idx_reg + IDX_ONE;
                tcnt_reg <= '0;
            end
        end
    end

    always_comb begin
        busy     = (state_reg == S_WAIT) || (state_reg == S_CHECK);
        done     = (state_reg == S_PASS) || (state_reg == S_FAIL);
        pass     = (state_reg == S_PASS);
        fail     = (state_reg == S_FAIL);
        timeout  = (state_reg == S_FAIL) && timeout_reg;
        fail_idx = fail_idx_reg;
        fail_got = fail_got_reg;
    end

endmodule

// File: tb/tb_regfile_check_sequencer.sv
// Bench for regfile_check_sequencer: directed scenarios plus randomized tables checked
// against a shadow-register model that evaluates each check from the write history.
module tb_regfile_check_sequencer;
    localparam int NUM_CHECKS     = 8;
    localparam int FLAG_REG       = 20;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int XLEN           = 32;
    localparam int IDX_W          = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [XLEN-1:0]  cfg_flag;
    logic [4:0]       cfg_reg;
    logic [XLEN-1:0]  cfg_value;
    logic [IDX_W:0]   cfg_count;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [IDX_W-1:0] fail_idx;
    logic [XLEN-1:0]  fail_got;

    int num_tests  = 0;
    int num_failed = 0;
    logic [XLEN-1:0] model_shadow [32];

    regfile_check_sequencer #(
        .NUM_CHECKS(NUM_CHECKS),
        .FLAG_REG(FLAG_REG),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .XLEN(XLEN)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_flag(cfg_flag),
        .cfg_reg(cfg_reg), .cfg_value(cfg_value), .cfg_count(cfg_count),
        .start(start), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_idx(fail_idx), .fail_got(fail_got)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_shadow[i] = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wb_we = 1'b1; wb_rd = rd; wb_data = data;
        tick();
        wb_we = 1'b0;
        if (rd != 5'd0) model_shadow[rd] = data;
    endtask

    task automatic cfg_write(input int idx, input logic [XLEN-1:0] flag,
                             input logic [4:0] r, input logic [XLEN-1:0] v);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_flag = flag; cfg_reg = r; cfg_value = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int c);
        cfg_count = (IDX_W + 1)'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Writes for the three-entry table; returns in the cycle x20=2 becomes visible.
    task automatic drive_plan2(input logic [XLEN-1:0] x2val);
        wb_write(5'd1, 32'd300);
        wb_write(5'd20, 32'd1);
        tick();
        tick();
        wb_write(5'd1, 32'd500);
        wb_write(5'd2, x2val);
        wb_write(5'd20, 32'd2);
    endtask

    task automatic program_plan2();
        cfg_write(0, 32'd1, 5'd1, 32'd300);
        cfg_write(1, 32'd2, 5'd1, 32'd500);
        cfg_write(2, 32'd2, 5'd2, 32'd100);
    endtask

    task automatic test_reset();
        apply_reset();
        num_tests++;
        if ({busy, done, pass, fail, timeout} !== 5'b0) begin
            num_failed++;
            $display("FAIL reset_flags got=%b want=00000", {busy, done, pass, fail, timeout});
        end
        num_tests++;
        if (fail_idx !== '0 || fail_got !== '0) begin
            num_failed++;
            $display("FAIL reset_diag got idx=%0d val=%0d want 0/0", fail_idx, fail_got);
        end
        $display("[TB] reset: outputs idle");
    endtask

    task automatic test_single();
        apply_reset();
        cfg_write(0, 32'd1, 5'd1, 32'd300);
        do_start(1);
        wb_write(5'd1, 32'd300);
        wb_write(5'd20, 32'd1);
        num_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            num_failed++;
            $display("FAIL single_visible got busy=%b done=%b want 1/0", busy, done);
        end
        tick();
        num_tests++;
        if (busy !== 1'b1) begin
            num_failed++;
            $display("FAIL single_check_cycle got busy=%b want 1", busy);
        end
        tick();
        num_tests++;
        if ({busy, done, pass, fail} !== 4'b0110) begin
            num_failed++;
            $display("FAIL single_result got busy/done/pass/fail=%b want 0110", {busy, done, pass, fail});
        end
        $display("[TB] single entry: done=%b pass=%b", done, pass);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        program_plan2();
        do_start(3);
        drive_plan2(32'd100);
        tick(); tick(); tick();
        num_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            num_failed++;
            $display("FAIL b2b_second_check got busy=%b done=%b want 1/0", busy, done);
        end
        tick();
        num_tests++;
        if ({done, pass, fail} !== 3'b110) begin
            num_failed++;
            $display("FAIL b2b_result got done/pass/fail=%b want 110", {done, pass, fail});
        end
        $display("[TB] three entries: done=%b pass=%b", done, pass);
    endtask

    task automatic test_mismatch();
        apply_reset();
        program_plan2();
        do_start(3);
        drive_plan2(32'd99);
        tick(); tick(); tick(); tick();
        num_tests++;
        if ({done, pass, fail, timeout} !== 4'b1010) begin
            num_failed++;
            $display("FAIL mismatch_flags got done/pass/fail/to=%b want 1010", {done, pass, fail, timeout});
        end
        num_tests++;
        if (fail_idx !== 3'd2 || fail_got !== 32'd99) begin
            num_failed++;
            $display("FAIL mismatch_diag got idx=%0d val=%0d want 2/99", fail_idx, fail_got);
        end
        $display("[TB] mismatch: fail_idx=%0d fail_got=%0d", fail_idx, fail_got);
    endtask

    task automatic test_timeout();
        apply_reset();
        cfg_write(0, 32'd7, 5'd1, 32'd0);
        do_start(1);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        num_tests++;
        if (busy !== 1'b1 || fail !== 1'b0) begin
            num_failed++;
            $display("FAIL timeout_early got busy=%b fail=%b want 1/0", busy, fail);
        end
        tick();
        num_tests++;
        if ({done, pass, fail, timeout} !== 4'b1011) begin
            num_failed++;
            $display("FAIL timeout_flags got done/pass/fail/to=%b want 1011", {done, pass, fail, timeout});
        end
        num_tests++;
        if (fail_idx !== 3'd0 || fail_got !== 32'd0) begin
            num_failed++;
            $display("FAIL timeout_diag got idx=%0d val=%0d want 0/0", fail_idx, fail_got);
        end
        $display("[TB] timeout: timeout=%b after %0d cycles", timeout, TIMEOUT_CYCLES);
    endtask

    task automatic test_zero_count();
        do_start(0);
        num_tests++;
        if ({busy, done, pass, fail} !== 4'b0110) begin
            num_failed++;
            $display("FAIL zero_count got busy/done/pass/fail=%b want 0110", {busy, done, pass, fail});
        end
        $display("[TB] zero count: pass=%b", pass);
    endtask

    task automatic test_x0_cfg_busy();
        apply_reset();
        wb_write(5'd0, 32'd5);
        cfg_write(0, 32'd0, 5'd0, 32'd0);
        do_start(1);
        cfg_write(0, 32'd9, 5'd3, 32'd1234);
        tick();
        num_tests++;
        if ({done, pass, fail} !== 3'b110) begin
            num_failed++;
            $display("FAIL x0_check got done/pass/fail=%b want 110", {done, pass, fail});
        end
        do_start(1);
        tick(); tick();
        num_tests++;
        if ({done, pass, fail} !== 3'b110) begin
            num_failed++;
            $display("FAIL cfg_busy_rerun got done/pass/fail=%b want 110", {done, pass, fail});
        end
        $display("[TB] x0 check and busy cfg write: pass=%b", pass);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        program_plan2();
        do_start(3);
        wb_write(5'd1, 32'd300);
        rst = 1'b1;
        tick();
        num_tests++;
        if ({busy, done, pass, fail, timeout} !== 5'b0 || fail_idx !== '0 || fail_got !== '0) begin
            num_failed++;
            $display("FAIL reset_mid got busy/done/pass/fail/to=%b idx=%0d val=%0d want all 0",
                     {busy, done, pass, fail, timeout}, fail_idx, fail_got);
        end
        rst = 1'b0;
        clear_model();
        do_start(1);
        wb_write(5'd20, 32'd1);
        tick(); tick();
        num_tests++;
        if ({done, fail, timeout} !== 3'b110 || fail_got !== 32'd0) begin
            num_failed++;
            $display("FAIL reset_mid_shadow got done/fail/to=%b x1=%0d want 110/0", {done, fail, timeout}, fail_got);
        end
        wb_write(5'd20, 32'd0);
        do_start(3);
        drive_plan2(32'd100);
        tick(); tick(); tick(); tick();
        num_tests++;
        if ({done, pass, fail} !== 3'b110) begin
            num_failed++;
            $display("FAIL reset_mid_rerun got done/pass/fail=%b want 110", {done, pass, fail});
        end
        $display("[TB] reset mid-sequence: rerun pass=%b", pass);
    endtask

    task automatic test_random(input int iters);
        logic [XLEN-1:0] flags [NUM_CHECKS];
        logic [XLEN-1:0] vals  [NUM_CHECKS];
        logic [4:0]      regs  [NUM_CHECKS];
        for (int it = 0; it < iters; it++) begin
            int c;
            int n;
            int exp_k;
            logic exp_fail;
            logic [XLEN-1:0] exp_got;
            logic [XLEN-1:0] wv;
            for (int k = 0; k < NUM_CHECKS; k++) begin
                regs[k] = 5'($urandom_range(0, 31));
                if (regs[k] == 5'(FLAG_REG)) regs[k] = 5'd21;
                vals[k] = $urandom;
                if (regs[k] == 5'd0 && $urandom_range(0, 1) == 1) vals[k] = '0;
                flags[k] = $urandom;
                while (flags[k] == model_shadow[FLAG_REG] || (k > 0 && flags[k] == flags[k-1]))
                    flags[k] = $urandom;
                cfg_write(k, flags[k], regs[k], vals[k]);
            end
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(1, 8));
            n = (c > NUM_CHECKS) ? NUM_CHECKS : c;
            do_start(c);
            exp_fail = 1'b0;
            exp_k = 0;
            exp_got = '0;
            for (int k = 0; k < n; k++) begin
                wv = ($urandom_range(0, 4) == 0) ? (vals[k] ^ ($urandom | 32'd1)) : vals[k];
                wb_write(regs[k], wv);
                wb_write(5'(FLAG_REG), flags[k]);
                tick(); tick(); tick();
                if (model_shadow[regs[k]] !== vals[k]) begin
                    exp_fail = 1'b1;
                    exp_k = k;
                    exp_got = model_shadow[regs[k]];
                    break;
                end
            end
            num_tests++;
            if ({done, pass, fail, timeout} !== {1'b1, !exp_fail, exp_fail, 1'b0}) begin
                num_failed++;
                $display("FAIL rand%0d_flags got done/pass/fail/to=%b want %b", it,
                         {done, pass, fail, timeout}, {1'b1, !exp_fail, exp_fail, 1'b0});
            end
            if (exp_fail) begin
                num_tests++;
                if (fail_idx !== IDX_W'(exp_k) || fail_got !== exp_got) begin
                    num_failed++;
                    $display("FAIL rand%0d_diag got idx=%0d val=%h want %0d/%h", it, fail_idx, fail_got, exp_k, exp_got);
                end
            end
            $display("[TB] random %0d: count=%0d entries=%0d expect_fail=%b idx=%0d", it, c, n, exp_fail, exp_k);
        end
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_flag = '0; cfg_reg = '0; cfg_value = '0;
        cfg_count = '0; start = 1'b0;
        clear_model();
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_count();
        test_mismatch();
        test_timeout();
        test_x0_cfg_busy();
        test_reset_mid();
        test_random(24);
        $display("[TB] %0d tests run, %0d failed", num_tests, num_failed);
        $finish;
    end

endmodule
